// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_WAIT_DEF = 3;
  localparam int unsigned STARVE_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_IF,
    ST_BUSY_LS
  } arb_state_e;

endpackage

// File: rtl/mem_arb_if.sv
// Single-outstanding memory request/response port shared by IFU and LSU.
interface mem_arb_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of LSU wins taken while the IFU was waiting.
module arb_starve_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] sat_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < sat_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arb.sv
// Arbitrates one memory port between instruction fetch and load/store,
// with a starvation limit on consecutive LSU wins and fetch-flush dropping.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_wstrb,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  mem_arb_if.master   mem,
  input  logic        i_flush,
  output logic        o_stall_f,
  output logic        o_stall_m
);

  localparam logic [STARVE_W-1:0] SAT = STARVE_W'(MAX_WAIT);

  arb_state_e          state_q;
  logic                drop_q;
  logic [STARVE_W-1:0] starve;
  logic                idle, if_ok, pick_ls, pick_if;

  assign idle  = (state_q == ST_IDLE);
  assign if_ok = i_if_req & ~i_flush;
  // LSU loses priority only once the IFU has waited MAX_WAIT grants and can actually go.
  assign pick_ls = idle & i_ls_req & ((starve < SAT) | ~if_ok);
  assign pick_if = idle & ~pick_ls & if_ok;

  always_comb begin
    mem.req   = pick_ls | pick_if;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    mem.wstrb = '0;
    if (pick_ls) begin
      mem.we    = i_ls_we;
      mem.addr  = i_ls_addr;
      mem.wdata = i_ls_wdata;
      mem.wstrb = i_ls_wstrb;
    end else if (pick_if) begin
      mem.addr  = i_if_addr;
    end
  end

  assign o_if_gnt = pick_if & mem.ready;
  assign o_ls_gnt = pick_ls & mem.ready;

  assign o_if_rdata  = mem.rdata;
  assign o_ls_rdata  = mem.rdata;
  // A flush in the response cycle itself must also suppress the fetch data.
  assign o_if_rvalid = mem.rvalid & (state_q == ST_BUSY_IF) & ~(drop_q | i_flush);
  assign o_ls_rvalid = mem.rvalid & (state_q == ST_BUSY_LS);

  assign o_stall_f = i_if_req & ~o_if_rvalid;
  assign o_stall_m = (i_ls_req | (state_q == ST_BUSY_LS)) & ~o_ls_rvalid;

  arb_starve_cnt #(
    .W (STARVE_W)
  ) u_starve (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .inc_i (o_ls_gnt & i_if_req),
    .clr_i (o_if_gnt),
    .sat_i (SAT),
    .cnt_o (starve)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drop_q <= 1'b0;
          if (o_if_gnt) begin
            state_q <= ST_BUSY_IF;
          end else if (o_ls_gnt) begin
            state_q <= ST_BUSY_LS;
          end
        end
        ST_BUSY_IF: begin
          if (mem.rvalid) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
          end else if (i_flush) begin
            drop_q  <= 1'b1;
          end
        end
        ST_BUSY_LS: begin
          if (mem.rvalid) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          drop_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 3, max consecutive LSU wins while IFU is waiting (range 1..7).
REQ-002 SHALL have ports: i_clk  in  1  sole clock, rising edge; i_rst  in  1  synchronous active-high reset.
REQ-003 SHALL have IFU ports: i_if_req in 1 fetch request; i_if_addr in 32 fetch address; o_if_gnt out 1 request accepted; o_if_rvalid out 1 fetch data valid; o_if_rdata out 32 fetch data.
REQ-004 SHALL have LSU ports: i_ls_req in 1; i_ls_we in 1 write; i_ls_addr in 32; i_ls_wdata in 32; i_ls_wstrb in 4; o_ls_gnt out 1; o_ls_rvalid out 1 load data or store ack; o_ls_rdata out 32.
REQ-005 SHALL have memory ports: o_m_req out 1; o_m_we out 1; o_m_addr out 32; o_m_wdata out 32; o_m_wstrb out 4; i_m_ready in 1 request accepted; i_m_rvalid in 1 response; i_m_rdata in 32.
REQ-006 SHALL have control ports: i_flush in 1 branch/jump flush; o_stall_f out 1 hold fetch/decode; o_stall_m out 1 hold pipeline at MEM.

Function
REQ-007 SHALL share one memory port between IFU and LSU with at most one outstanding transaction.
REQ-008 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS.
REQ-009 In IDLE, SHALL drive o_m_req/addr/we/wdata/wstrb combinationally from the selected requester; none selected -> o_m_req=0, other outputs 0.
REQ-010 Selection in IDLE: LSU if i_ls_req and starve count < MAX_WAIT; else IFU if i_if_req; else LSU if i_ls_req.
REQ-011 IFU requests SHALL drive o_m_we=0, o_m_wdata=0, o_m_wstrb=0.
REQ-012 Handshake: transfer occurs when o_m_req & i_m_ready; same cycle the selected o_*_gnt=1 and FSM moves to BUSY_IF or BUSY_LS next cycle.
REQ-013 Without i_m_ready, SHALL hold selection stable only if the selected requester keeps req high; requesters SHALL keep req/addr stable until gnt.
REQ-014 In BUSY_*, o_m_req=0 and no grant; i_m_rvalid returns FSM to IDLE next cycle; no back-to-back issue in the response cycle.
REQ-015 o_if_rdata and o_ls_rdata SHALL equal i_m_rdata combinationally; o_if_rvalid = i_m_rvalid & BUSY_IF & ~drop; o_ls_rvalid = i_m_rvalid & BUSY_LS.
REQ-016 Starve counter, 3 bits: +1 on each LSU grant while i_if_req=1; cleared on IFU grant; saturates at MAX_WAIT.
REQ-017 i_flush in BUSY_IF (including rvalid cycle) SHALL set drop flag; drop suppresses o_if_rvalid and clears on return to IDLE.
REQ-018 i_flush in IDLE SHALL block IFU selection that cycle; LSU traffic unaffected by i_flush.
REQ-019 o_stall_f = i_if_req & ~o_if_rvalid; o_stall_m = i_ls_req & ~o_ls_rvalid, plus o_stall_m held while BUSY_LS.
REQ-020 i_m_rvalid in IDLE SHALL be ignored (no rvalid to either side).
REQ-021 Simultaneous IFU and LSU request with starve < MAX_WAIT: LSU wins; IFU stalls.

Reset
REQ-022 i_rst at a clock edge: state IDLE, starve count 0, drop 0; all outputs follow IDLE rules with no requests (o_m_req=0, gnt=0, rvalid=0).
REQ-023 Reset mid-transaction SHALL abandon the transaction; memory slave is reset from the same i_rst.

Structure
REQ-024 FSM state encodings and MAX_WAIT default SHALL live in the core shared package.
REQ-025 Starve counter SHALL be a sub-module arb_starve_cnt (inc, clr, sat level, count out); rest flat.

Verification
REQ-026 IFU-only read addr 0x100, i_m_ready=1, rvalid 2 cycles later with 0xDEADBEEF -> o_if_gnt cycle 0, o_if_rvalid with 0xDEADBEEF, o_stall_f low after.
REQ-027 Both req every cycle, MAX_WAIT=3, zero-wait memory -> grant order LS,LS,LS,IF repeating; starve count 0 after each IF grant.
REQ-028 LSU store addr 0x200, wdata 0x12345678, wstrb 0xF, i_m_ready low 3 cycles -> o_m_req held 4 cycles, gnt on 4th, o_ls_rvalid on ack, o_stall_m high until ack.
REQ-029 i_flush during BUSY_IF, then rvalid -> o_if_rvalid stays 0, FSM back to IDLE, next IFU fetch served normally.
REQ-030 i_rst asserted in BUSY_LS -> next cycle IDLE, all outputs 0; stray i_m_rvalid in IDLE produces no rvalid.
